// File: rtl/tdm_demux4.sv
// Receive side of the 4-channel TDM link: gathers slots 0..3 of a frame into shadow
// registers and publishes all four channel words together, flagging early-sof aborts.
module tdm_demux4 #(
   parameter int W     = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             EN,
   input  logic [W-1:0]     din,
   input  logic             din_vld,
   input  logic             sof,
   output logic [W-1:0]     A,
   output logic [W-1:0]     B,
   output logic [W-1:0]     C,
   output logic [W-1:0]     D,
   output logic             frame_vld,
   output logic             frame_err,
   output logic [1:0]       slot,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic {ST_IDLE = 1'b0, ST_RECV = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r, state_s;
   logic [1:0]       slot_s;
   logic [W-1:0]     sh0_r, sh1_r, sh2_r;
   logic [W-1:0]     sh0_s, sh1_s, sh2_s;
   logic [W-1:0]     a_s, b_s, c_s, d_s;
   logic             vld_s, err_s;
   logic [CNT_W-1:0] cnt_s;
   logic             accept_s;

   // Next-state and next-output computation for the frame collector.
   always_comb begin
      state_s  = state_r;
      slot_s   = slot;
      sh0_s    = sh0_r;
      sh1_s    = sh1_r;
      sh2_s    = sh2_r;
      a_s      = A;
      b_s      = B;
      c_s      = C;
      d_s      = D;
      vld_s    = 1'b0;
      err_s    = 1'b0;
      cnt_s    = frame_cnt;
      accept_s = (EN == 1'b0) && din_vld;

      case (state_r)
         ST_IDLE: begin
            // Beats without sof while idle are orphans and silently dropped.
            if (accept_s && sof) begin
               sh0_s   = din;
               slot_s  = 2'd1;
               state_s = ST_RECV;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (accept_s && sof) begin
               // Early sof aborts the partial frame and starts a new one with this beat.
               err_s  = 1'b1;
               sh0_s  = din;
               slot_s = 2'd1;
            end else if (accept_s) begin
               case (slot)
                  2'd1: begin
                     sh1_s  = din;
                     slot_s = 2'd2;
                  end
                  2'd2: begin
                     sh2_s  = din;
                     slot_s = 2'd3;
                  end
                  2'd3: begin
                     a_s     = sh0_r;
                     b_s     = sh1_r;
                     c_s     = sh2_r;
                     d_s     = din;
                     vld_s   = 1'b1;
                     cnt_s   = frame_cnt + CNT_ONE;
                     slot_s  = 2'd0;
                     state_s = ST_IDLE;
                  end
                  default: begin
                     slot_s  = 2'd0;
                     state_s = ST_IDLE;
                  end
               endcase
            end else begin
               state_s = ST_RECV;
            end
         end
         default: begin
            state_s = ST_IDLE;
            slot_s  = 2'd0;
         end
      endcase
   end

   // State, shadow and output registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         slot      <= 2'd0;
         busy      <= 1'b0;
         sh0_r     <= '0;
         sh1_r     <= '0;
         sh2_r     <= '0;
         A         <= '0;
         B         <= '0;
         C         <= '0;
         D         <= '0;
         frame_vld <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state_r   <= state_s;
         slot      <= slot_s;
         busy      <= (state_s == ST_RECV);
         sh0_r     <= sh0_s;
         sh1_r     <= sh1_s;
         sh2_r     <= sh2_s;
         A         <= a_s;
         B         <= b_s;
         C         <= c_s;
         D         <= d_s;
         frame_vld <= vld_s;
         frame_err <= err_s;
         frame_cnt <= cnt_s;
      end
   end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4; a second instance with a 2-bit
// counter covers frame-counter wrap.
module tb_tdm_demux4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       EN = 1'b0;
   logic [1:0] din = 2'd0;
   logic       din_vld = 1'b0;
   logic       sof = 1'b0;

   logic [1:0] A, B, C, D, slot;
   logic       frame_vld, frame_err, busy;
   logic [7:0] frame_cnt;

   logic [1:0] a2, b2, c2, d2, slot2;
   logic       vld2, err2, busy2;
   logic [1:0] cnt2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   tdm_demux4 #(.W(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .EN(EN), .din(din), .din_vld(din_vld), .sof(sof),
      .A(A), .B(B), .C(C), .D(D), .frame_vld(frame_vld), .frame_err(frame_err),
      .slot(slot), .busy(busy), .frame_cnt(frame_cnt)
   );

   tdm_demux4 #(.W(2), .CNT_W(2)) dut_wrap (
      .clk(clk), .rst(rst), .EN(EN), .din(din), .din_vld(din_vld), .sof(sof),
      .A(a2), .B(b2), .C(c2), .D(d2), .frame_vld(vld2), .frame_err(err2),
      .slot(slot2), .busy(busy2), .frame_cnt(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge with the given inputs; returns 1 time unit after the edge.
   task automatic step(input logic en, input logic vld, input logic sf, input logic [1:0] d);
      EN = en; din_vld = vld; sof = sf; din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic sf, input logic [1:0] d);
      step(1'b0, 1'b1, sf, d);
   endtask

   task automatic frame(input logic [1:0] d0, input logic [1:0] d1,
                        input logic [1:0] d2, input logic [1:0] d3);
      beat(1'b1, d0);
      beat(1'b0, d1);
      beat(1'b0, d2);
      beat(1'b0, d3);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 1'b0, 2'd0);
      rst = 1'b0;
   endtask

   task automatic check_abcd(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                             input logic [1:0] ec, input logic [1:0] ed);
      check({tag, "_A"}, A, ea);
      check({tag, "_B"}, B, eb);
      check({tag, "_C"}, C, ec);
      check({tag, "_D"}, D, ed);
   endtask

   initial begin
      // 1: reset
      @(negedge clk);
      do_reset();
      check_abcd("rst", 2'd0, 2'd0, 2'd0, 2'd0);
      check("rst_vld", frame_vld, 1'b0);
      check("rst_err", frame_err, 1'b0);
      check("rst_slot", slot, 2'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_cnt", frame_cnt, 8'd0);

      // 2: single frame
      beat(1'b1, 2'd1);
      check("t2_slot1", slot, 2'd1);
      check("t2_busy", busy, 1'b1);
      beat(1'b0, 2'd2);
      beat(1'b0, 2'd3);
      check("t2_slot3", slot, 2'd3);
      check("t2_vld_pre", frame_vld, 1'b0);
      beat(1'b0, 2'd0);
      check_abcd("t2", 2'd1, 2'd2, 2'd3, 2'd0);
      check("t2_vld", frame_vld, 1'b1);
      check("t2_cnt", frame_cnt, 8'd1);
      check("t2_busy_end", busy, 1'b0);
      check("t2_slot_end", slot, 2'd0);
      step(1'b0, 1'b0, 1'b0, 2'd0);
      check("t2_vld_drop", frame_vld, 1'b0);
      check_abcd("t2_hold", 2'd1, 2'd2, 2'd3, 2'd0);

      // 3: gaps and freeze
      do_reset();
      beat(1'b1, 2'd3);
      step(1'b0, 1'b0, 1'b0, 2'd1);
      check("t3_gap_slot", slot, 2'd1);
      beat(1'b0, 2'd2);
      step(1'b1, 1'b1, 1'b0, 2'd0);
      check("t3_frz_slot", slot, 2'd2);
      check("t3_frz_busy", busy, 1'b1);
      step(1'b1, 1'b1, 1'b1, 2'd3);
      check("t3_frz_sof_err", frame_err, 1'b0);
      check("t3_frz_sof_slot", slot, 2'd2);
      beat(1'b0, 2'd1);
      check("t3_A_held", A, 2'd0);
      beat(1'b0, 2'd0);
      check_abcd("t3", 2'd3, 2'd2, 2'd1, 2'd0);
      check("t3_vld", frame_vld, 1'b1);
      check("t3_cnt", frame_cnt, 8'd1);

      // 4: early sof (A..D from test 3 still held)
      beat(1'b1, 2'd1);
      beat(1'b0, 2'd2);
      beat(1'b1, 2'd3);
      check("t4_err", frame_err, 1'b1);
      check("t4_slot", slot, 2'd1);
      check_abcd("t4_held", 2'd3, 2'd2, 2'd1, 2'd0);
      beat(1'b0, 2'd0);
      check("t4_err_drop", frame_err, 1'b0);
      beat(1'b0, 2'd1);
      check("t4_vld_pre", frame_vld, 1'b0);
      beat(1'b0, 2'd2);
      check_abcd("t4", 2'd3, 2'd0, 2'd1, 2'd2);
      check("t4_vld", frame_vld, 1'b1);
      check("t4_cnt", frame_cnt, 8'd2);

      // 5: orphans then back-to-back frames
      do_reset();
      beat(1'b0, 2'd2);
      beat(1'b0, 2'd2);
      check("t5_orph_slot", slot, 2'd0);
      check("t5_orph_busy", busy, 1'b0);
      check("t5_orph_err", frame_err, 1'b0);
      frame(2'd1, 2'd1, 2'd2, 2'd3);
      check("t5_f1_vld", frame_vld, 1'b1);
      check_abcd("t5_f1", 2'd1, 2'd1, 2'd2, 2'd3);
      beat(1'b1, 2'd2);
      check("t5_f2_b0_vld", frame_vld, 1'b0);
      check("t5_f2_b0_busy", busy, 1'b1);
      beat(1'b0, 2'd3);
      check("t5_f2_b1_vld", frame_vld, 1'b0);
      beat(1'b0, 2'd0);
      check("t5_f2_b2_vld", frame_vld, 1'b0);
      beat(1'b0, 2'd1);
      check("t5_f2_vld", frame_vld, 1'b1);
      check_abcd("t5_f2", 2'd2, 2'd3, 2'd0, 2'd1);
      check("t5_cnt", frame_cnt, 8'd2);

      // 6: counter wrap and mid-frame reset
      do_reset();
      for (int i = 0; i < 5; i++) frame(2'd0, 2'd1, 2'd2, 2'd3);
      check("t6_cnt_wrap", cnt2, 2'd1);
      check("t6_cnt_wide", frame_cnt, 8'd5);
      beat(1'b1, 2'd3);
      beat(1'b0, 2'd2);
      check("t6_mid_busy", busy, 1'b1);
      rst = 1'b1;
      step(1'b0, 1'b1, 1'b1, 2'd1);
      rst = 1'b0;
      check_abcd("t6_rst", 2'd0, 2'd0, 2'd0, 2'd0);
      check("t6_rst_err", frame_err, 1'b0);
      check("t6_rst_vld", frame_vld, 1'b0);
      check("t6_rst_slot", slot, 2'd0);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_cnt", frame_cnt, 8'd0);
      check("t6_rst_cnt2", cnt2, 2'd0);
      check("t6_rst_A2", a2, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
